mem_stream_reader: RTL
======================

MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 512, meaning memory depth in words; AW = $clog2(DEPTH).
REQ-003 The block SHALL have port clk  input  1  meaning single clock for all logic.
REQ-004 The block SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-005 The block SHALL have port cmd_valid  input  1  meaning read command offered.
REQ-006 The block SHALL have port cmd_ready  output  1  meaning command accepted when cmd_valid&cmd_ready.
REQ-007 The block SHALL have port cmd_base  input  AW  meaning first word address.
REQ-008 The block SHALL have port cmd_len  input  AW+1  meaning word count, 0..DEPTH.
REQ-009 The block SHALL have port mem_en  output  1  meaning memory read-port enable.
REQ-010 The block SHALL have port mem_addr  output  AW  meaning memory read-port address.
REQ-011 The block SHALL have port mem_dout  input  WIDTH  meaning memory read data, valid one cycle after mem_en; holds value when mem_en=0.
REQ-012 The block SHALL have port m_valid  output  1  meaning stream beat valid.
REQ-013 The block SHALL have port m_ready  input  1  meaning sink accepts beat.
REQ-014 The block SHALL have port m_data  output  WIDTH  meaning stream beat data.
REQ-015 The block SHALL have port m_last  output  1  meaning final beat of command.
REQ-016 The block SHALL have port done  output  1  meaning one-cycle pulse at command completion.

Function
REQ-017 FSM SHALL have states IDLE, RUN, DRAIN; cmd_ready=1 only in IDLE.
REQ-018 IDLE: on cmd_valid with cmd_len>0 SHALL latch base/len, clear issue/deliver counters, go RUN.
REQ-019 IDLE: on cmd_valid with cmd_len=0 SHALL produce no beats, pulse done next cycle, stay IDLE.
REQ-020 RUN: a read SHALL issue (mem_en=1, mem_addr=base+issued mod DEPTH) when issued<len and (fifo_count + inflight - pop) < 2, pop = m_valid&m_ready.
REQ-021 Address SHALL wrap modulo DEPTH (base=DEPTH-2, len=4 -> DEPTH-2, DEPTH-1, 0, 1).
REQ-022 Data SHALL be captured from mem_dout exactly in the cycle after an issue, never otherwise.
REQ-023 Captured words SHALL enter a 2-entry output FIFO; m_valid = FIFO non-empty; m_data = FIFO head; beats in address order.
REQ-024 Simultaneous push and pop SHALL keep count unchanged; FIFO SHALL never overflow.
REQ-025 Sustained throughput SHALL be 1 beat/cycle with m_ready held 1; first beat m_valid 2 cycles after command accept.
REQ-026 m_last SHALL be 1 with the beat whose delivered index = len-1, 0 otherwise.
REQ-027 RUN -> DRAIN when issued reaches len; DRAIN -> IDLE on acceptance of the m_last beat, with done pulsing that same cycle.
REQ-028 m_valid, m_data, m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-029 len=DEPTH SHALL read every address exactly once.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, FIFO empty, counters 0, mem_en=0, mem_addr=0, m_valid=0, m_data=0, m_last=0, done=0, cmd_ready=1 after release.
REQ-031 Reset mid-command SHALL abandon the command; in-flight read data SHALL be discarded; no done pulse.

Structure
REQ-032 FIFO depth constant (2) and FSM state encoding SHALL reside in shared package mem_stream_pkg.
REQ-033 The 2-entry output FIFO SHALL be sub-module skid_fifo2 (WIDTH+1 bits: data+last).
REQ-034 Block SHALL connect directly to the existing dual-port mem read port (enB/addrB/doutB).

Verification
REQ-035 Memory preloaded mem[i]=i+100; cmd base=5 len=3, m_ready=1 -> beats 105,106,107, last on 107, done same cycle as 107 accepted.
REQ-036 base=510 len=4, DEPTH=512 -> addresses 510,511,0,1, data 610,611,100,101.
REQ-037 len=8, m_ready toggling 1,0,0,1 repeating -> 8 beats in order, no loss/duplication, data stable during stalls, mem_en never issued with 2 words buffered/in flight.
REQ-038 len=0 -> no m_valid, done pulses 1 cycle after accept.
REQ-039 rst_n low after 3 beats of len=10 -> all outputs 0 at once; new cmd base=0 len=2 then yields 100,101 only.
REQ-040 len=512, m_ready=1 -> 512 beats on consecutive cycles, beat k = k+100.

Source files
------------

// File: rtl/mem_stream_pkg.sv
// Shared definitions for the memory stream reader.
// Holds the output FIFO depth and the reader FSM state encoding so the top
// level and the FIFO agree on both.
package mem_stream_pkg;

    // Number of words the output FIFO can hold. The issue throttle also uses
    // this value to bound buffered plus in-flight words.
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/mem_stream_reader_skid_fifo2.sv
// skid_fifo2: two-entry FIFO between the memory capture point and the
// output stream.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   push, push_data    write one entry (never issued while full)
//   pop                remove head entry (only while valid)
//   count              current occupancy 0..2
//   valid, head        non-empty flag and head entry
module skid_fifo2
    import mem_stream_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic         valid,
    output logic [W-1:0] head
);

    logic [W-1:0] mem_r [FIFO_DEPTH];
    logic         rd_ptr_r;
    logic         wr_ptr_r;
    logic [1:0]   count_r;

    // Storage, pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;
    assign valid = (count_r != 2'd0);
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: turns a (base, length) read command into a stream of
// words fetched from a synchronous memory read port.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_base/cmd_len   read command handshake
//   mem_en/mem_addr/mem_dout           memory read port, one-cycle latency
//   m_valid/m_ready/m_data/m_last      output stream
//   done                               one-cycle pulse when a command completes
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [AW-1:0]    cmd_base,
    input  logic [AW:0]      cmd_len,
    output logic             mem_en,
    output logic [AW-1:0]    mem_addr,
    input  logic [WIDTH-1:0] mem_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             done
);

    state_e        state_r;
    state_e        state_s;
    logic [AW-1:0] addr_r;
    logic [AW:0]   len_r;
    logic [AW:0]   issued_r;
    logic [AW:0]   cap_idx_r;
    logic          inflight_r;
    logic          zero_done_r;

    logic          issue_s;
    logic          pop_s;
    logic          accept_s;
    logic [2:0]    occupancy_s;
    logic [1:0]    fifo_count_s;
    logic          fifo_valid_s;
    logic [WIDTH:0] fifo_head_s;
    logic [WIDTH:0] push_data_s;

    // Issue throttle and next-state logic. Occupancy counts words buffered or
    // in flight after this cycle's pop, so the FIFO can never overflow.
    always_comb begin
        state_s     = state_r;
        pop_s       = fifo_valid_s & m_ready;
        accept_s    = 1'b0;
        occupancy_s = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        issue_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && (cmd_len != '0)) begin
                    accept_s = 1'b1;
                    state_s  = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                issue_s = (issued_r < len_r) && (occupancy_s < 3'(FIFO_DEPTH));
                if (issue_s && ((issued_r + (AW+1)'(1)) == len_r)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (pop_s && fifo_head_s[WIDTH]) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Command registers, issue/capture counters and the read-data pipeline flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            len_r       <= '0;
            issued_r    <= '0;
            cap_idx_r   <= '0;
            inflight_r  <= 1'b0;
            zero_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            inflight_r  <= issue_s;
            zero_done_r <= (state_r == ST_IDLE) && cmd_valid && (cmd_len == '0);
            if (accept_s) begin
                addr_r    <= cmd_base;
                len_r     <= cmd_len;
                issued_r  <= '0;
                cap_idx_r <= '0;
            end else begin
                if (issue_s) begin
                    issued_r <= issued_r + (AW+1)'(1);
                    // Wrap explicitly so non-power-of-two depths also work.
                    if (addr_r == AW'(DEPTH - 1)) begin
                        addr_r <= '0;
                    end else begin
                        addr_r <= addr_r + AW'(1);
                    end
                end
                if (inflight_r) begin
                    cap_idx_r <= cap_idx_r + (AW+1)'(1);
                end
            end
        end
    end

    // The last flag is decided at capture time and travels with the word.
    assign push_data_s = {(cap_idx_r == (len_r - (AW+1)'(1))), mem_dout};

    skid_fifo2 #(
        .W (WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_r),
        .push_data (push_data_s),
        .pop       (pop_s),
        .count     (fifo_count_s),
        .valid     (fifo_valid_s),
        .head      (fifo_head_s)
    );

    assign cmd_ready = (state_r == ST_IDLE);
    assign mem_en    = issue_s;
    assign mem_addr  = issue_s ? addr_r : '0;
    assign m_valid   = fifo_valid_s;
    // Gate stale slot contents so nothing leaks out while the FIFO is empty.
    assign m_data    = fifo_valid_s ? fifo_head_s[WIDTH-1:0] : '0;
    assign m_last    = fifo_valid_s & fifo_head_s[WIDTH];
    assign done      = zero_done_r | ((state_r == ST_DRAIN) & pop_s & fifo_head_s[WIDTH]);

endmodule
